// File: rtl/uart_tx_core.sv
// uart_tx_core: TX FIFO feeding an 8N1 serializer, LSB first.
// Every bit lasts CLK_DIV clocks; txd comes straight from a flop.
module uart_tx_core #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    input  logic                          fifo_rst,
    output logic                          txd,
    output logic                          tx_full,
    output logic                          tx_empty,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          push, pop, fifo_empty, baud_end;

    // Wrap bit differs and index matches: all entries occupied.
    assign tx_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign wr_ready   = ~tx_full & ~fifo_rst;
    assign push       = wr_valid & wr_ready;
    assign baud_end   = (baud_q == BAUD_MAX);
    assign pop        = ~fifo_empty & ~fifo_rst &
                        ((state_q == S_IDLE) |
                         ((state_q == S_STOP) & baud_end));
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_empty   = fifo_empty & ~tx_busy;
    assign txd        = txd_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        if (fifo_rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_end ? '0 : baud_q + BW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            S_IDLE: baud_d = '0;
            S_START: begin
                if (baud_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: if (baud_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A pop in S_STOP chains straight into the next start bit.
        if (pop) begin
            shift_d = mem_q[rd_ptr_q[AW-1:0]];
            baud_d  = '0;
            state_d = S_START;
        end
        txd_d = 1'b1;
        if (state_d == S_START)     txd_d = 1'b0;
        else if (state_d == S_DATA) txd_d = shift_d[0];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Transmit back end of the UART peripheral. It accepts bytes from the bus-facing register block (one per TX-register write), buffers them in a TX FIFO, and serialises them onto txd as 8N1 frames, LSB first, at a fixed clock divisor. It reports FIFO and transmitter status for the UART status register (Tx-Full, Tx-Empty). It also honours the control-register "Rst Tx FIFO" bit.

Parameters:
CLK_DIV, 16, clk cycles per serial bit; legal values are >= 2.
FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2 and >= 2.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
wr_valid  input  1  byte offered by the register block
wr_data  input  8  byte to transmit
wr_ready  output  1  FIFO can accept a byte
fifo_rst  input  1  synchronous TX FIFO clear, one-cycle pulse
txd  output  1  serial line; idle level is high
tx_full  output  1  FIFO holds FIFO_DEPTH entries
tx_empty  output  1  FIFO empty and serializer idle
tx_busy  output  1  serializer is not in S_IDLE
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of FIFO entries

Behaviour:
- Reset values: txd=1, wr_ready=1, tx_full=0, tx_empty=1, tx_busy=0, fifo_count=0, state=S_IDLE, FIFO pointers=0.
- Reset is asynchronous. Asserting rst_n mid-frame forces txd=1 immediately. The current frame and all queued bytes are discarded.
- Write handshake: a byte is accepted on a rising edge when wr_valid & wr_ready.
  - wr_ready = ~tx_full & ~fifo_rst.
  - A pop in the same cycle does not make room for a write when the FIFO is full (full is registered).
- fifo_count: +1 on write, -1 on pop, unchanged on simultaneous write and pop. Range is 0..FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- fifo_rst: clears pointers and count on the next edge. It takes priority over a concurrent write, which is dropped. A frame already in the shift register completes normally.
- Serializer FSM:
  - S_IDLE: txd=1. If the FIFO is non-empty: pop into shift_reg, clear baud_cnt, go to S_START.
  - S_START: txd=0 for CLK_DIV cycles, then go to S_DATA with bit_idx=0.
  - S_DATA: txd=shift_reg[0] for CLK_DIV cycles per bit, then shift right and bit_idx+1. After bit 7 go to S_STOP.
  - S_STOP: txd=1 for CLK_DIV cycles.
    - On the last cycle, if the FIFO is non-empty: pop and go directly to S_START (no idle gap).
    - Otherwise go to S_IDLE.
- baud_cnt counts 0..CLK_DIV-1. A bit period ends when baud_cnt==CLK_DIV-1. Every bit lasts exactly CLK_DIV cycles, so a frame is 10*CLK_DIV cycles.
- txd is driven from a flop (glitch-free).
- Latency: a byte accepted at edge E into an empty FIFO with the serializer idle is popped at edge E+1. txd falls after E+1.
- Status outputs:
  - tx_empty = (fifo_count==0) & (state==S_IDLE).
  - tx_busy = (state!=S_IDLE).
  - tx_full = (fifo_count==FIFO_DEPTH).

Test Plan:
- Single byte, CLK_DIV=4, FIFO_DEPTH=4: reset, then write 0xA5. Required response:
  - txd levels, 4 cycles each: 0 (start), 1,0,1,0,0,1,0,1, 1 (stop).
  - Frame lasts 40 cycles.
  - tx_busy=1 throughout the frame; tx_empty=1 after the stop bit.
- Overflow/back-pressure: write 0x01..0x06 on consecutive cycles with wr_valid held high. Required response:
  - 0x01 is popped immediately.
  - 0x02..0x05 fill the FIFO: tx_full=1, fifo_count=4, wr_ready=0.
  - 0x06 stalls until the pop at the end of frame 1, then is accepted.
  - Six frames of 40 cycles go out back-to-back, 240 cycles with txd never idle-high between stop and start.
- fifo_rst mid-frame: with 0x11 transmitting and 0x22,0x33,0x44 queued, pulse fifo_rst during data bit 3. Required response:
  - fifo_count=0 the next cycle.
  - The 0x11 frame completes intact, then txd=1 steady and tx_empty=1.
- Simultaneous write and fifo_rst on an empty FIFO with wr_data=0x5A: wr_ready=0 and the byte is dropped. fifo_count stays 0 and no frame is sent.
- Async reset mid-frame: assert rst_n low during data bit 5 of 0xFF with 2 bytes queued, between clock edges. Required response:
  - txd=1 and fifo_count=0 without waiting for a clock edge.
  - After release, no frame is sent.
- Simultaneous write and pop at FIFO count 2: fifo_count stays 2, and byte order is preserved across a pointer wrap.
